// File: rtl/keyboard_scan_encoder.sv
// keyboard_scan_encoder
//   Turns four debounced key levels (up/down/left/right) into a PS/2 set-2
//   style byte stream. A press emits the make code. A release emits 0xF0 and
//   then the make code. When REPEAT_CYCLES > 0, held keys re-emit their make
//   code periodically (typematic repeat).
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   key_up     in   key level, 1 = held (index 0)
//   key_down   in   key level, 1 = held (index 1)
//   key_left   in   key level, 1 = held (index 2)
//   key_right  in   key level, 1 = held (index 3)
//   scan_code  out  emitted byte; holds its last value between strobes
//   scan_ready out  one-clock strobe per emitted byte
//   busy       out  high whenever the sequencer is not idle
module keyboard_scan_encoder #(
    parameter logic [7:0] CODE_UP       = 8'h1D,
    parameter logic [7:0] CODE_DOWN     = 8'h1B,
    parameter logic [7:0] CODE_LEFT     = 8'h1C,
    parameter logic [7:0] CODE_RIGHT    = 8'h23,
    parameter int         GAP_CYCLES    = 4,
    parameter int         REPEAT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    output logic [7:0] scan_code,
    output logic       scan_ready,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, GAP, PFX_GAP, BRK_CODE} state_t;

    localparam int            GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [7:0]    BREAK_PFX = 8'hF0;

    function automatic logic [7:0] code_of(input logic [1:0] idx);
        case (idx)
            2'd0:    code_of = CODE_UP;
            2'd1:    code_of = CODE_DOWN;
            2'd2:    code_of = CODE_LEFT;
            default: code_of = CODE_RIGHT;
        endcase
    endfunction

    logic [3:0]    key_in;
    logic [3:0]    key_q;
    logic [3:0]    press, release_ev;
    logic [3:0]    press_pend_q, press_pend_d;
    logic [3:0]    rel_pend_q, rel_pend_d;
    logic [3:0]    serve_press, serve_rel;
    state_t        state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          scan_ready_q, scan_ready_d;
    logic          sel_valid, sel_press;
    logic [1:0]    sel_idx;
    logic          rpt_fire;

    assign key_in     = {key_right, key_left, key_down, key_up};
    assign press      = key_in & ~key_q;
    assign release_ev = ~key_in & key_q;

    // Typematic counter: runs only while keys are steadily held. Any edge or
    // an all-released keyboard restarts the period from zero.
    generate
        if (REPEAT_CYCLES > 0) begin : g_repeat
            localparam int            RW       = $clog2(REPEAT_CYCLES + 1);
            localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
            logic [RW-1:0] rpt_cnt_q;
            logic          any_edge;

            assign any_edge = |(press | release_ev);
            assign rpt_fire = !any_edge && (|key_q) && (rpt_cnt_q == RPT_LAST);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rpt_cnt_q <= '0;
                end else if (any_edge || !(|key_q) || rpt_cnt_q == RPT_LAST) begin
                    rpt_cnt_q <= '0;
                end else begin
                    rpt_cnt_q <= rpt_cnt_q + 1'b1;
                end
            end
        end else begin : g_no_repeat
            assign rpt_fire = 1'b0;
        end
    endgenerate

    // Lowest-index key with anything pending wins; its press goes before its
    // release so that a short tap is reproduced in full.
    always_comb begin
        sel_valid = 1'b0;
        sel_press = 1'b0;
        sel_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (press_pend_q[i] || rel_pend_q[i]) begin
                sel_valid = 1'b1;
                sel_press = press_pend_q[i];
                sel_idx   = 2'(i);
            end
        end
    end

    // Pending flags: the served flag is cleared and new events are OR-ed in
    // on the same edge, so an event landing during service is not lost.
    always_comb begin
        serve_press = '0;
        serve_rel   = '0;
        if (state_q == IDLE && sel_valid) begin
            if (sel_press) serve_press = 4'b0001 << sel_idx;
            else           serve_rel   = 4'b0001 << sel_idx;
        end
        press_pend_d = (press_pend_q & ~serve_press) | press | (rpt_fire ? key_q : 4'b0000);
        rel_pend_d   = (rel_pend_q & ~serve_rel) | release_ev;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            idx_q        <= 2'd0;
            key_q        <= 4'b0000;
            press_pend_q <= 4'b0000;
            rel_pend_q   <= 4'b0000;
            scan_code_q  <= 8'h00;
            scan_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            idx_q        <= idx_d;
            key_q        <= key_in;
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            scan_code_q  <= scan_code_d;
            scan_ready_q <= scan_ready_d;
        end
    end

    // Next-state logic. Both wait states last exactly GAP_CYCLES clocks, so
    // consecutive strobes are always GAP_CYCLES+1 clocks or more apart.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        idx_d     = idx_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d   = sel_press ? GAP : PFX_GAP;
                    idx_d     = sel_idx;
                    gap_cnt_d = '0;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            PFX_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = BRK_CODE;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: begin
                state_d   = GAP;
                gap_cnt_d = '0;
            end
        endcase
    end

    // Output logic: values registered into scan_code_q / scan_ready_q.
    always_comb begin
        scan_code_d  = scan_code_q;
        scan_ready_d = 1'b0;
        if (state_q == IDLE && sel_valid) begin
            scan_code_d  = sel_press ? code_of(sel_idx) : BREAK_PFX;
            scan_ready_d = 1'b1;
        end else if (state_q == BRK_CODE) begin
            scan_code_d  = code_of(idx_q);
            scan_ready_d = 1'b1;
        end
    end

    assign scan_code  = scan_code_q;
    assign scan_ready = scan_ready_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_keyboard_scan_encoder.sv
module tb_keyboard_scan_encoder;

    typedef struct {
        int         cyc;
        logic [7:0] code;
    } strobe_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_up, key_down, key_left, key_right;
    logic [3:0] k2;
    logic [7:0] code1, code2;
    logic       rdy1, rdy2, busy1, busy2;

    int      cyc = 0;
    int      n_total = 0;
    int      n_bad = 0;
    strobe_t q1[$];
    strobe_t q2[$];
    logic    busy_h[4096];
    int      moves = 0;
    int      wide = 0;
    logic    dec_brk = 1'b0;
    logic    rdy1_prev = 1'b0;

    int         t5_off[7]  = '{2, 22, 42, 62, 82, 97, 102};
    logic [7:0] t5_code[7] = '{8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B};

    always #5 clk = ~clk;

    keyboard_scan_encoder dut1 (
        .clk(clk), .rst(rst),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .scan_code(code1), .scan_ready(rdy1), .busy(busy1)
    );

    keyboard_scan_encoder #(.REPEAT_CYCLES(20)) dut2 (
        .clk(clk), .rst(rst),
        .key_up(k2[0]), .key_down(k2[1]), .key_left(k2[2]), .key_right(k2[3]),
        .scan_code(code2), .scan_ready(rdy2), .busy(busy2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe logger plus a small scan-code decoder model on dut1's stream.
    always @(negedge clk) begin
        if (rdy1) q1.push_back('{cyc, code1});
        if (rdy2) q2.push_back('{cyc, code2});
        if (cyc < 4096) busy_h[cyc] <= busy1;
        if (rdy1 && rdy1_prev) wide <= wide + 1;
        rdy1_prev <= rdy1;
        if (!rst) begin
            dec_brk <= 1'b0;
        end else if (rdy1) begin
            if (dec_brk)              dec_brk <= 1'b0;
            else if (code1 == 8'hF0)  dec_brk <= 1'b1;
            else                      moves   <= moves + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe idx (relative to base) of stream 'which': value = cycle*256 + code.
    task automatic chk_st(input string tag, input int which, input int idx,
                          input int ecyc, input logic [7:0] ecode);
        logic [31:0] obs;
        obs = 32'hFFFF_FFFF;
        if (which == 1) begin
            if (idx < q1.size()) obs = 32'(q1[idx].cyc * 256 + int'(q1[idx].code));
        end else begin
            if (idx < q2.size()) obs = 32'(q2[idx].cyc * 256 + int'(q2[idx].code));
        end
        chk(tag, obs, 32'(ecyc * 256 + int'(ecode)));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0, c1, r, b, bc;
        rst = 1'b0;
        key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
        k2 = 4'b0000;
        tick(3);
        chk("rst_code", 32'(code1), 32'h00);
        chk("rst_ready", 32'(rdy1), 32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        rst = 1'b1;
        tick(3);

        // T1: key_up press
        b = q1.size(); c0 = cyc;
        key_up = 1'b1;
        tick(12);
        chk("t1_count", 32'(q1.size() - b), 32'd1);
        chk_st("t1_make", 1, b, c0 + 2, 8'h1D);
        bc = 0;
        for (int i = c0; i < c0 + 12; i++) bc += int'(busy_h[i]);
        chk("t1_busy_cycles", 32'(bc), 32'd4);
        chk("t1_busy_first", 32'(busy_h[c0 + 2]), 32'h1);
        chk("t1_busy_end", 32'(busy_h[c0 + 6]), 32'h0);
        chk("t1_code_hold", 32'(code1), 32'h1D);

        // T2: key_up release
        b = q1.size(); c0 = cyc;
        key_up = 1'b0;
        tick(20);
        chk("t2_count", 32'(q1.size() - b), 32'd2);
        chk_st("t2_f0", 1, b, c0 + 2, 8'hF0);
        chk_st("t2_code", 1, b + 1, c0 + 7, 8'h1D);

        // T3: simultaneous press of right and up, then simultaneous release
        b = q1.size(); c0 = cyc;
        key_right = 1'b1; key_up = 1'b1;
        tick(20);
        chk("t3_count", 32'(q1.size() - b), 32'd2);
        chk_st("t3_up", 1, b, c0 + 2, 8'h1D);
        chk_st("t3_right", 1, b + 1, c0 + 7, 8'h23);
        b = q1.size(); c0 = cyc;
        key_right = 1'b0; key_up = 1'b0;
        tick(30);
        chk("t3r_count", 32'(q1.size() - b), 32'd4);
        chk_st("t3r_f0a", 1, b, c0 + 2, 8'hF0);
        chk_st("t3r_up", 1, b + 1, c0 + 7, 8'h1D);
        chk_st("t3r_f0b", 1, b + 2, c0 + 12, 8'hF0);
        chk_st("t3r_right", 1, b + 3, c0 + 17, 8'h23);

        // T4: one-clock tap of key_left while busy emitting key_down
        b = q1.size(); c0 = cyc;
        key_down = 1'b1;
        tick(2);
        key_left = 1'b1;
        tick(1);
        key_left = 1'b0;
        tick(27);
        chk("t4_count", 32'(q1.size() - b), 32'd4);
        chk_st("t4_down", 1, b, c0 + 2, 8'h1B);
        chk_st("t4_left", 1, b + 1, c0 + 7, 8'h1C);
        chk_st("t4_f0", 1, b + 2, c0 + 12, 8'hF0);
        chk_st("t4_left_brk", 1, b + 3, c0 + 17, 8'h1C);
        b = q1.size(); c0 = cyc;
        key_down = 1'b0;
        tick(20);
        chk("t4r_count", 32'(q1.size() - b), 32'd2);
        chk_st("t4r_f0", 1, b, c0 + 2, 8'hF0);
        chk_st("t4r_down", 1, b + 1, c0 + 7, 8'h1B);

        // T5: typematic on dut2, key_down held for 95 clocks
        chk("t5_idle", 32'(q2.size()), 32'd0);
        b = q2.size(); c0 = cyc;
        k2[1] = 1'b1;
        tick(95);
        k2[1] = 1'b0;
        tick(65);
        chk("t5_count", 32'(q2.size() - b), 32'd7);
        for (int i = 0; i < 7; i++) chk_st($sformatf("t5_strobe%0d", i), 2, b + i, c0 + t5_off[i], t5_code[i]);

        // T6: reset between 0xF0 and its code, key_right held through reset
        b = q1.size(); c0 = cyc;
        key_up = 1'b1;
        tick(10);
        c1 = cyc;
        key_up = 1'b0; key_right = 1'b1;
        tick(3);
        rst = 1'b0;
        #1;
        chk("t6_async_code", 32'(code1), 32'h00);
        chk("t6_async_ready", 32'(rdy1), 32'h0);
        chk("t6_async_busy", 32'(busy1), 32'h0);
        tick(3);
        rst = 1'b1;
        r = cyc;
        tick(20);
        chk("t6_count", 32'(q1.size() - b), 32'd3);
        chk_st("t6_make", 1, b, c0 + 2, 8'h1D);
        chk_st("t6_f0", 1, b + 1, c1 + 2, 8'hF0);
        chk_st("t6_fresh", 1, b + 2, r + 2, 8'h23);
        key_right = 1'b0;
        tick(20);

        // Decoder-chain summary over dut1's whole stream
        chk("dec_moves", 32'(moves), 32'd7);
        chk("dec_wide_strobe", 32'(wide), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
